axi_write_arbiter: RTL and testbench
====================================

Name: axi_write_arbiter

Overview:
- Shares one AXI slave write path (AW, W, B channels) between NUM_MASTERS requesters.
- Round-robin arbitration on AW. The grant is held from AW acceptance through the B response, so exactly one write transaction is outstanding at a time.
- Sits between the master-side write channels and the axi_slave write ports.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8).
- DATA_BITS, 32, W data width.
- ADDR_BITS, 32, AW address width.
- LEN_BITS, 8, AW burst length field width (beats = len+1).
- SIZE_BITS, 3, AW size field width.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- m_aw_valid  in  NUM_MASTERS  per-master AW valid.
- m_aw_ready  out  NUM_MASTERS  per-master AW ready.
- m_aw_addr  in  NUM_MASTERS*ADDR_BITS  packed addresses; master i at slice i.
- m_aw_len  in  NUM_MASTERS*LEN_BITS  packed burst lengths.
- m_aw_size  in  NUM_MASTERS*SIZE_BITS  packed sizes.
- m_w_valid / m_w_ready  in/out  NUM_MASTERS  per-master W handshake.
- m_w_data  in  NUM_MASTERS*DATA_BITS  packed write data.
- m_w_strb  in  NUM_MASTERS*DATA_BITS/8  packed strobes.
- m_w_last  in  NUM_MASTERS  per-master last beat.
- m_b_valid / m_b_ready  out/in  NUM_MASTERS  per-master B handshake.
- m_b_resp  out  NUM_MASTERS*2  packed responses.
- s_aw_valid, s_aw_ready, s_aw_addr, s_aw_len, s_aw_size  out/in/out/out/out  1/1/ADDR_BITS/LEN_BITS/SIZE_BITS  slave AW.
- s_w_valid, s_w_ready, s_w_data, s_w_strb, s_w_last  out/in/out/out/out  1/1/DATA_BITS/DATA_BITS/8/1  slave W.
- s_b_valid, s_b_ready, s_b_resp  in/out/in  1/1/2  slave B.
- busy  out  1  high whenever state != IDLE.
- grant_id  out  $clog2(NUM_MASTERS)  currently granted master; valid while busy.
- err_wlast  out  1  sticky; w_last did not fall on beat len+1. Cleared only by reset.

Behaviour:
- Reset: at the clock edge where areset=1, state=IDLE, grant_id=0, rr_ptr=0, beat_cnt=0, err_wlast=0. All outputs are low, including every m_*_ready, m_b_valid, s_aw_valid, s_w_valid and s_b_ready.
- Reset mid-transaction: the transaction is abandoned with no B returned. Outputs are low from the edge on which reset is sampled.
- FSM IDLE:
  - If any m_aw_valid is high, grant the first requester at or after rr_ptr (cyclic search).
  - Register grant_id, go to ADDR.
  - All ready outputs stay low in IDLE, so no handshake completes there.
- FSM ADDR:
  - s_aw_* = granted master's AW fields; m_aw_ready[grant] = s_aw_ready; other m_aw_ready = 0.
  - On s_aw_valid & s_aw_ready: capture len into len_q, clear beat_cnt, go to DATA.
- FSM DATA:
  - s_w_* driven from the granted master; m_w_ready[grant] = s_w_ready; all others 0.
  - Each W handshake increments beat_cnt (LEN_BITS+1 bits wide, no wrap).
  - On a handshake with s_w_last=1: go to RESP. If beat_cnt != len_q, set err_wlast.
  - A beat reaching len_q+1 without last also sets err_wlast. The FSM still waits for last.
- FSM RESP:
  - s_b_ready = m_b_ready[grant]; m_b_valid[grant] = s_b_valid; m_b_resp slice[grant] = s_b_resp.
  - Other m_b_valid are 0; other m_b_resp slices are 0.
  - On the B handshake: rr_ptr = (grant_id+1) mod NUM_MASTERS, go to IDLE.
- Latency:
  - m_aw_valid sampled in IDLE at edge N gives s_aw_valid high from cycle N+1.
  - After the B handshake at edge M, the next grant can be sampled at edge M+1, so s_aw_valid rises at M+2.
- Muxing: channel routing is combinational from registered grant_id and state, so payload has zero added latency. The state and grant only change on handshake edges.
- Master side: a non-granted master's valid is ignored and never dropped. It waits with ready=0.
- Simultaneous requests: the master nearest rr_ptr (cyclic) wins. A single persistent requester is re-granted every transaction.
- len=0: a single beat with last is legal and sets no error.

Decomposition:
- Shared package axi_pkg:
  - resp enum OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - FSM state enum {IDLE, ADDR, DATA, RESP}.
- Sub-module rr_arbiter (parameter N): inputs req[N], ptr; outputs grant_idx, any_req. Purely combinational cyclic priority search, reusable for a future read arbiter.

Test Plan:
- Single master 0, AW addr 0x1000, len=3, 4 beats with last on beat 4, slave bresp OKAY:
  - s_aw_addr=0x1000 one cycle after request.
  - 4 W beats forwarded.
  - m_b_resp[0]=00; busy falls after B.
  - err_wlast=0.
- Masters 0 and 1 both request continuously, len=0 each:
  - Grants alternate 0,1,0,1.
  - The non-granted master never sees aw_ready, w_ready or b_valid high.
- Slave stalls (s_aw_ready low 5 cycles, s_w_ready toggling, s_b_valid delayed 7 cycles):
  - All payload held stable; no beat lost or duplicated.
  - State advances only on handshakes.
- Master 1 sends len=2 but asserts last on beat 2 -> err_wlast=1 after that beat; FSM enters RESP; err_wlast stays set through later transactions.
- areset asserted during DATA (beat 2 of 4):
  - Next cycle all outputs are low, busy=0, grant_id=0.
  - A new request after reset release is granted to master 0.
- Slave returns SLVERR to master 1 with m_b_ready[1] low 3 cycles -> s_b_ready low those cycles; m_b_resp[1]=10 held until handshake.

Source files
------------

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - AXI response codes and write-arbiter FSM states
package axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10,
    RESP = 2'b11
  } arb_state_e;

endpackage

// File: rtl/axi_write_arbiter_if.sv
// rtl/axi_write_arbiter_if.sv - packed per-master write channels plus the shared slave write port
// slave modport is the arbiter's view; master modport is the surrounding masters and slave.
interface axi_write_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int DATA_BITS   = 32,
  parameter int ADDR_BITS   = 32,
  parameter int LEN_BITS    = 8,
  parameter int SIZE_BITS   = 3
);
  logic [NUM_MASTERS-1:0]             m_aw_valid;
  logic [NUM_MASTERS-1:0]             m_aw_ready;
  logic [NUM_MASTERS*ADDR_BITS-1:0]   m_aw_addr;
  logic [NUM_MASTERS*LEN_BITS-1:0]    m_aw_len;
  logic [NUM_MASTERS*SIZE_BITS-1:0]   m_aw_size;
  logic [NUM_MASTERS-1:0]             m_w_valid;
  logic [NUM_MASTERS-1:0]             m_w_ready;
  logic [NUM_MASTERS*DATA_BITS-1:0]   m_w_data;
  logic [NUM_MASTERS*DATA_BITS/8-1:0] m_w_strb;
  logic [NUM_MASTERS-1:0]             m_w_last;
  logic [NUM_MASTERS-1:0]             m_b_valid;
  logic [NUM_MASTERS-1:0]             m_b_ready;
  logic [NUM_MASTERS*2-1:0]           m_b_resp;

  logic                   s_aw_valid;
  logic                   s_aw_ready;
  logic [ADDR_BITS-1:0]   s_aw_addr;
  logic [LEN_BITS-1:0]    s_aw_len;
  logic [SIZE_BITS-1:0]   s_aw_size;
  logic                   s_w_valid;
  logic                   s_w_ready;
  logic [DATA_BITS-1:0]   s_w_data;
  logic [DATA_BITS/8-1:0] s_w_strb;
  logic                   s_w_last;
  logic                   s_b_valid;
  logic                   s_b_ready;
  logic [1:0]             s_b_resp;

  modport slave (
    input  m_aw_valid, m_aw_addr, m_aw_len, m_aw_size,
    output m_aw_ready,
    input  m_w_valid, m_w_data, m_w_strb, m_w_last,
    output m_w_ready,
    output m_b_valid, m_b_resp,
    input  m_b_ready,
    output s_aw_valid, s_aw_addr, s_aw_len, s_aw_size,
    input  s_aw_ready,
    output s_w_valid, s_w_data, s_w_strb, s_w_last,
    input  s_w_ready,
    input  s_b_valid, s_b_resp,
    output s_b_ready
  );

  modport master (
    output m_aw_valid, m_aw_addr, m_aw_len, m_aw_size,
    input  m_aw_ready,
    output m_w_valid, m_w_data, m_w_strb, m_w_last,
    input  m_w_ready,
    input  m_b_valid, m_b_resp,
    output m_b_ready,
    input  s_aw_valid, s_aw_addr, s_aw_len, s_aw_size,
    output s_aw_ready,
    input  s_w_valid, s_w_data, s_w_strb, s_w_last,
    output s_w_ready,
    output s_b_valid, s_b_resp,
    input  s_b_ready
  );
endinterface

// File: rtl/axi_write_arbiter_rr.sv
// rtl/axi_write_arbiter_rr.sv - combinational cyclic-priority search starting at ptr
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant_idx,
  output logic          any_req
);

  // Scan farthest-to-nearest so the requester closest to ptr is written last and wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant_idx = '0;
    any_req   = |req;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (req[idx]) grant_idx = IW'(idx);
    end
  end

endmodule

// File: rtl/axi_write_arbiter.sv
// rtl/axi_write_arbiter.sv - round-robin sharing of one AXI write path, one transaction in flight
module axi_write_arbiter
  import axi_pkg::*;
#(
  parameter  int NUM_MASTERS = 2,
  parameter  int DATA_BITS   = 32,
  parameter  int ADDR_BITS   = 32,
  parameter  int LEN_BITS    = 8,
  parameter  int SIZE_BITS   = 3,
  localparam int GW          = $clog2(NUM_MASTERS)
) (
  input  logic                aclk,
  input  logic                areset,
  axi_write_arbiter_if.slave  bus,
  output logic                busy,
  output logic [GW-1:0]       grant_id,
  output logic                err_wlast
);

  localparam int SB = DATA_BITS / 8;

  arb_state_e          state_q, state_d;
  logic [GW-1:0]       grant_q, rr_ptr_q, arb_idx;
  logic                any_req;
  logic [LEN_BITS-1:0] len_q;
  logic [LEN_BITS:0]   beat_cnt_q;
  logic                err_q;
  logic                aw_hs, w_hs, w_last, b_hs;

  rr_arbiter #(.N(NUM_MASTERS)) u_rr (
    .req       (bus.m_aw_valid),
    .ptr       (rr_ptr_q),
    .grant_idx (arb_idx),
    .any_req   (any_req)
  );

  // Handshakes are derived from inputs so the routing block never reads back its own outputs.
  assign aw_hs  = (state_q == ADDR) && bus.m_aw_valid[grant_q] && bus.s_aw_ready;
  assign w_hs   = (state_q == DATA) && bus.m_w_valid[grant_q] && bus.s_w_ready;
  assign w_last = bus.m_w_last[grant_q];
  assign b_hs   = (state_q == RESP) && bus.s_b_valid && bus.m_b_ready[grant_q];

  assign busy      = (state_q != IDLE);
  assign grant_id  = grant_q;
  assign err_wlast = err_q;

  always_comb begin
    state_d        = state_q;
    bus.m_aw_ready = '0;
    bus.m_w_ready  = '0;
    bus.m_b_valid  = '0;
    bus.m_b_resp   = '0;
    bus.s_aw_valid = 1'b0;
    bus.s_aw_addr  = '0;
    bus.s_aw_len   = '0;
    bus.s_aw_size  = '0;
    bus.s_w_valid  = 1'b0;
    bus.s_w_data   = '0;
    bus.s_w_strb   = '0;
    bus.s_w_last   = 1'b0;
    bus.s_b_ready  = 1'b0;
    unique case (state_q)
      IDLE: if (any_req) state_d = ADDR;
      ADDR: begin
        bus.s_aw_valid          = bus.m_aw_valid[grant_q];
        bus.s_aw_addr           = bus.m_aw_addr[int'(grant_q)*ADDR_BITS +: ADDR_BITS];
        bus.s_aw_len            = bus.m_aw_len[int'(grant_q)*LEN_BITS +: LEN_BITS];
        bus.s_aw_size           = bus.m_aw_size[int'(grant_q)*SIZE_BITS +: SIZE_BITS];
        bus.m_aw_ready[grant_q] = bus.s_aw_ready;
        if (aw_hs) state_d = DATA;
      end
      DATA: begin
        bus.s_w_valid          = bus.m_w_valid[grant_q];
        bus.s_w_data           = bus.m_w_data[int'(grant_q)*DATA_BITS +: DATA_BITS];
        bus.s_w_strb           = bus.m_w_strb[int'(grant_q)*SB +: SB];
        bus.s_w_last           = w_last;
        bus.m_w_ready[grant_q] = bus.s_w_ready;
        if (w_hs && w_last) state_d = RESP;
      end
      RESP: begin
        bus.s_b_ready                        = bus.m_b_ready[grant_q];
        bus.m_b_valid[grant_q]               = bus.s_b_valid;
        bus.m_b_resp[int'(grant_q)*2 +: 2]   = bus.s_b_resp;
        if (b_hs) state_d = IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: if (any_req) grant_q <= arb_idx;
        ADDR: if (aw_hs) begin
          len_q      <= bus.s_aw_len;
          beat_cnt_q <= '0;
        end
        DATA: if (w_hs) begin
          if (beat_cnt_q != '1) beat_cnt_q <= beat_cnt_q + 1'b1;
          // Flag last arriving early/late, or the beat len+1 arriving without last.
          if (w_last ? (beat_cnt_q != {1'b0, len_q}) : (beat_cnt_q == {1'b0, len_q}))
            err_q <= 1'b1;
        end
        RESP: if (b_hs)
          rr_ptr_q <= (grant_q == GW'(NUM_MASTERS - 1)) ? '0 : grant_q + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// tb/tb_axi_write_arbiter.sv - table-driven transactions plus reset-in-DATA sequence
module tb_axi_write_arbiter;
  import axi_pkg::*;

  localparam int N = 2, DB = 32, AB = 32, LB = 8, SZ = 3;

  logic       aclk = 1'b0;
  logic       areset = 1'b1;
  logic       busy;
  logic [0:0] grant_id;
  logic       err_wlast;

  always #5 aclk = ~aclk;

  axi_write_arbiter_if #(.NUM_MASTERS(N), .DATA_BITS(DB), .ADDR_BITS(AB),
                         .LEN_BITS(LB), .SIZE_BITS(SZ)) bus ();

  axi_write_arbiter #(.NUM_MASTERS(N), .DATA_BITS(DB), .ADDR_BITS(AB),
                      .LEN_BITS(LB), .SIZE_BITS(SZ)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .bus       (bus),
    .busy      (busy),
    .grant_id  (grant_id),
    .err_wlast (err_wlast)
  );

  typedef struct {
    int          m;
    bit          other_req;
    bit          keep;
    logic [31:0] addr;
    int          len;
    int          nbeats;
    logic [1:0]  resp;
    int          aw_stall;
    bit          w_toggle;
    int          b_delay;
    int          bready_stall;
    bit          exp_err;
  } txn_t;

  txn_t        vec[9];
  int          total = 0;
  int          bad = 0;
  int          mon_beats = 0;
  logic [31:0] mon_sum = '0;
  bit          prev_keep = 0;

  always @(posedge aclk)
    if (bus.s_w_valid && bus.s_w_ready) begin
      mon_beats = mon_beats + 1;
      mon_sum   = mon_sum + bus.s_w_data;
    end

  function automatic logic [31:0] wdat(int m, logic [31:0] a, int b);
    return a ^ 32'hD000_0000 ^ (32'(m) << 24) ^ 32'(b);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_txn(input txn_t t);
    int          o, n;
    bit          hs, tog;
    logic [31:0] exp_sum, d;
    o = 1 - t.m;
    @(posedge aclk); #1;
    bus.m_aw_valid[t.m]           = 1'b1;
    bus.m_aw_addr[t.m*AB +: AB]   = t.addr;
    bus.m_aw_len[t.m*LB +: LB]    = LB'(t.len);
    bus.m_aw_size[t.m*SZ +: SZ]   = 3'd2;
    if (t.other_req) begin
      bus.m_aw_valid[o]           = 1'b1;
      bus.m_aw_addr[o*AB +: AB]   = t.addr ^ 32'h0000_0F00;
      bus.m_aw_len[o*LB +: LB]    = LB'(t.len);
      bus.m_aw_size[o*SZ +: SZ]   = 3'd2;
    end
    mon_beats = 0;
    mon_sum   = '0;
    exp_sum   = '0;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!bus.s_aw_valid && n < 20);
    chk("aw_latency", 64'(n), prev_keep ? 64'd1 : 64'd2);
    chk("aw_fields", {bus.s_aw_addr, bus.s_aw_len, bus.s_aw_size}, {t.addr, LB'(t.len), 3'd2});
    chk("grant", {busy, grant_id}, {1'b1, 1'(t.m)});
    for (int i = 0; i < t.aw_stall; i++) begin
      @(posedge aclk); #1;
      @(negedge aclk);
      chk("aw_stall", {bus.s_aw_valid, bus.s_aw_addr, bus.m_aw_ready}, {1'b1, t.addr, 2'b00});
    end
    @(posedge aclk); #1;
    bus.s_aw_ready = 1'b1;
    @(negedge aclk);
    chk("aw_ready", {bus.m_aw_ready[t.m], bus.m_aw_ready[o]}, 2'b10);
    @(posedge aclk); #1;
    bus.s_aw_ready = 1'b0;
    if (!t.keep) bus.m_aw_valid[t.m] = 1'b0;

    tog = 1'b1;
    for (int b = 0; b < t.nbeats; b++) begin
      d = wdat(t.m, t.addr, b);
      exp_sum = exp_sum + d;
      bus.m_w_valid[t.m]          = 1'b1;
      bus.m_w_data[t.m*DB +: DB]  = d;
      bus.m_w_strb[t.m*4 +: 4]    = 4'hF;
      bus.m_w_last[t.m]           = (b == t.nbeats - 1);
      tog = ~tog;
      bus.s_w_ready = t.w_toggle ? tog : 1'b1;
      hs = 1'b0;
      n = 0;
      while (!hs && n < 20) begin
        @(negedge aclk);
        n++;
        chk("w_fwd", {bus.s_w_valid, bus.s_w_last, bus.s_w_strb, bus.s_w_data, bus.m_w_ready[o]},
            {1'b1, 1'(b == t.nbeats - 1), 4'hF, d, 1'b0});
        hs = bus.s_w_ready;
        @(posedge aclk); #1;
        if (!hs) begin
          tog = ~tog;
          bus.s_w_ready = t.w_toggle ? tog : 1'b1;
        end
      end
      if (!hs) chk("w_timeout", 64'd0, 64'd1);
    end
    bus.m_w_valid[t.m] = 1'b0;
    bus.m_w_last[t.m]  = 1'b0;
    bus.s_w_ready      = 1'b0;
    bus.s_b_valid      = 1'b0;
    bus.s_b_resp       = t.resp;
    bus.m_b_ready[t.m] = (t.bready_stall == 0);
    @(negedge aclk);
    chk("err_after_last", 64'(err_wlast), 64'(t.exp_err));
    chk("w_beats", {32'(mon_beats), mon_sum}, {32'(t.nbeats), exp_sum});

    for (int i = 0; i < t.b_delay; i++) begin
      @(posedge aclk); #1;
      @(negedge aclk);
      chk("b_wait", {busy, bus.m_b_valid}, 3'b100);
    end
    @(posedge aclk); #1;
    bus.s_b_valid = 1'b1;
    for (int i = 0; i < t.bready_stall; i++) begin
      @(negedge aclk);
      chk("b_stall", {bus.s_b_ready, bus.m_b_valid[t.m], bus.m_b_resp[t.m*2 +: 2]}, {2'b01, t.resp});
      @(posedge aclk); #1;
    end
    bus.m_b_ready[t.m] = 1'b1;
    @(negedge aclk);
    chk("b_hs", {bus.s_b_ready, bus.m_b_valid[t.m], bus.m_b_resp[t.m*2 +: 2],
                 bus.m_b_valid[o], bus.m_b_resp[o*2 +: 2]}, {2'b11, t.resp, 3'b000});
    @(posedge aclk); #1;
    bus.s_b_valid      = 1'b0;
    bus.m_b_ready[t.m] = 1'b0;
    if (!t.keep) bus.m_aw_valid = '0;
    @(negedge aclk);
    chk("idle_after_b", {busy, err_wlast}, {1'b0, t.exp_err});
    prev_keep = t.keep;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t pr;
    //         m  oth keep addr           len nb resp    aws wt bd br err
    vec[0] = '{0, 0, 0, 32'h0000_1000, 3, 4, OKAY,   0, 0, 0, 0, 0};
    vec[1] = '{1, 0, 0, 32'h0000_2000, 1, 2, SLVERR, 0, 0, 0, 3, 0};
    vec[2] = '{0, 1, 1, 32'h0000_2100, 0, 1, OKAY,   0, 0, 0, 0, 0};
    vec[3] = '{1, 1, 1, 32'h0000_2200, 0, 1, EXOKAY, 0, 0, 0, 0, 0};
    vec[4] = '{0, 1, 1, 32'h0000_2300, 0, 1, DECERR, 0, 0, 0, 0, 0};
    vec[5] = '{1, 1, 0, 32'h0000_2400, 0, 1, OKAY,   0, 0, 0, 0, 0};
    vec[6] = '{0, 0, 0, 32'h0000_3000, 2, 3, OKAY,   5, 1, 7, 0, 0};
    vec[7] = '{1, 0, 0, 32'h0000_4000, 2, 2, OKAY,   0, 0, 0, 0, 1};
    vec[8] = '{0, 0, 0, 32'h0000_5000, 0, 1, OKAY,   0, 0, 0, 0, 1};

    bus.m_aw_valid = 2'b11;
    bus.m_aw_addr = '0; bus.m_aw_len = '0; bus.m_aw_size = '0;
    bus.m_w_valid = '0; bus.m_w_data = '0; bus.m_w_strb = '0; bus.m_w_last = '0;
    bus.m_b_ready = '0;
    bus.s_aw_ready = 1'b1; bus.s_w_ready = 1'b0; bus.s_b_valid = 1'b0; bus.s_b_resp = 2'b00;

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("reset_state", {busy, grant_id, err_wlast, bus.s_aw_valid, bus.m_aw_ready,
                        bus.s_w_valid, bus.s_b_ready, bus.m_b_valid}, '0);
    @(posedge aclk); #1;
    bus.m_aw_valid = '0;
    bus.s_aw_ready = 1'b0;
    areset = 1'b0;

    for (int i = 0; i < 9; i++) run_txn(vec[i]);

    // Reset lands while beat 2 of a 4-beat burst from master 1 is on the bus.
    @(posedge aclk); #1;
    bus.m_aw_valid[1]       = 1'b1;
    bus.m_aw_addr[AB +: AB] = 32'h0000_6000;
    bus.m_aw_len[LB +: LB]  = 8'd3;
    bus.s_aw_ready          = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    chk("rst_pre_aw", {bus.s_aw_valid, bus.s_aw_addr}, {1'b1, 32'h0000_6000});
    @(posedge aclk); #1;
    bus.s_aw_ready    = 1'b0;
    bus.m_aw_valid    = '0;
    bus.m_w_valid[1]  = 1'b1;
    bus.m_w_data[DB +: DB] = 32'h1111_0001;
    bus.s_w_ready     = 1'b1;
    @(posedge aclk); #1;
    bus.m_w_data[DB +: DB] = 32'h1111_0002;
    areset = 1'b1;
    @(negedge aclk);
    chk("rst_pre_edge", {busy, grant_id, bus.s_w_valid, bus.s_w_data}, {2'b11, 1'b1, 32'h1111_0002});
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("rst_mid_data", {busy, grant_id, err_wlast, bus.s_w_valid, bus.m_w_ready, bus.s_aw_valid,
                         bus.m_aw_ready, bus.s_b_ready, bus.m_b_valid, bus.s_w_data}, '0);
    @(posedge aclk); #1;
    areset = 1'b0;
    bus.m_w_valid = '0;
    bus.s_w_ready = 1'b0;
    prev_keep = 0;

    // Both request after reset: master 0 wins; an overlong burst flags err at beat len+1.
    pr = '{0, 1, 0, 32'h0000_7000, 1, 3, OKAY, 0, 0, 0, 0, 1};
    run_txn(pr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
